// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Registered ALU stage between decode and writeback. One op per transaction
//   over valid/ready handshakes on both sides. The result register and the
//   Z/N/P/C/err flags hold steady while the consumer applies backpressure.
//
//   Optional feature macro: ALU_PIPE_MUL_EN
//     defined     : op F is an unsigned shift-add multiply, one multiplier bit
//                   per cycle for WIDTH cycles (IDLE/MUL FSM present)
//     not defined : op F completes in one cycle with data 0 and err 1
//
// Parameters
//   WIDTH     datapath width (power of 2, >= 8)
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   op/a/b valid
//   in_ready   out  stage accepts a transaction this cycle
//   op         in   4-bit opcode
//   a, b       in   operands (b doubles as immediate / shift amount)
//   out_valid  out  result register holds an unconsumed result
//   out_ready  in   consumer takes the result this cycle
//   out_data   out  result
//   flag_z/n/p out  zero / negative / positive view of out_data
//   flag_c     out  ADD/SUB carry-out, MUL upper-half-nonzero, else 0
//   err        out  held result came from an illegal op
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_p,
  output logic             flag_c,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  logic             accept;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [2*WIDTH-1:0] rol_full;
  logic [2*WIDTH-1:0] ror_full;
  logic [WIDTH-1:0] btr;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_err;

  // Value presented to the result register this cycle
  logic             ld_en;
  logic [WIDTH-1:0] ld_data;
  logic             ld_c;
  logic             ld_err;
  logic             ld_zero;

  assign amt      = b[SHW-1:0];
  assign add_full = {1'b0, a} + {1'b0, b};
  // No-borrow carry: a + ~b + 1 sets bit WIDTH when a >= b unsigned
  assign sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  // Rotates via a doubled operand so amount 0 naturally returns a
  assign rol_full = {a, a} << amt;
  assign ror_full = {a, a} >> amt;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_btr
      assign btr[gi] = a[WIDTH-1-gi];
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (op)
      4'h0: begin alu_res = add_full[WIDTH-1:0]; alu_c = add_full[WIDTH]; end
      4'h1: begin alu_res = sub_full[WIDTH-1:0]; alu_c = sub_full[WIDTH]; end
      4'h2: alu_res = a ^ b;
      4'h3: alu_res = a & ~b;
      4'h4: alu_res = rol_full[2*WIDTH-1:WIDTH];
      4'h5: alu_res = a << amt;
      4'h6: alu_res = ror_full[WIDTH-1:0];
      4'h7: alu_res = a >> amt;
      4'h8: alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      4'h9: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'hA: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
      4'hB: alu_res = {{(WIDTH-1){1'b0}}, add_full[WIDTH]};
      4'hC: alu_res = btr;
      4'hD: alu_res = b;
      4'hE: alu_res = (a << (WIDTH/2)) | {{(WIDTH/2){1'b0}}, b[WIDTH/2-1:0]};
      // Op F reaches this path only when the multiplier is absent
      4'hF: alu_err = 1'b1;
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH-1);

  state_t             state_reg;
  logic [SHW-1:0]     cnt_reg;
  logic [2*WIDTH-1:0] mcand_reg;   // multiplicand, shifted left each cycle
  logic [WIDTH-1:0]   mplier_reg;  // multiplier, LSB is the current bit
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] prod_next;

  assign in_ready  = (state_reg == ST_IDLE) & (~out_valid | out_ready);
  assign prod_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_comb begin
    ld_en   = 1'b0;
    ld_data = alu_res;
    ld_c    = alu_c;
    ld_err  = alu_err;
    if (state_reg == ST_MUL && cnt_reg == CNT_LAST) begin
      ld_en   = 1'b1;
      ld_data = prod_next[WIDTH-1:0];
      ld_c    = |prod_next[2*WIDTH-1:WIDTH];
      ld_err  = 1'b0;
    end else if (accept && op != 4'hF) begin
      ld_en = 1'b1;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  always_comb begin
    ld_en   = accept;
    ld_data = alu_res;
    ld_c    = alu_c;
    ld_err  = alu_err;
  end
`endif

  assign accept  = in_valid & in_ready;
  assign ld_zero = (ld_data == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      flag_z     <= 1'b1;
      flag_n     <= 1'b0;
      flag_p     <= 1'b0;
      flag_c     <= 1'b0;
      err        <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
`endif
    end else begin
      if (ld_en) begin
        out_valid <= 1'b1;
        out_data  <= ld_data;
        flag_z    <= ld_zero;
        flag_n    <= ld_data[WIDTH-1] & ~ld_zero;
        flag_p    <= ~ld_data[WIDTH-1] & ~ld_zero;
        flag_c    <= ld_c;
        err       <= ld_err;
      end else if (out_ready) begin
        // Covers plain consumption and the MUL entry edge
        out_valid <= 1'b0;
      end

`ifdef ALU_PIPE_MUL_EN
      case (state_reg)
        ST_IDLE: begin
          if (accept && op == 4'hF) begin
            state_reg  <= ST_MUL;
            cnt_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
          end
        end
        ST_MUL: begin
          acc_reg    <= prod_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + SHW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        flag_z;
  logic        flag_n;
  logic        flag_p;
  logic        flag_c;
  logic        err;

  alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_p    (flag_p),
    .flag_c    (flag_c),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int txn   = 0;

  logic [20:0] sb_q[$];   // {data, z, n, p, c, err}
  logic [20:0] pend;
  logic        acc_now;
  logic        smp_in_ready;
  logic        smp_out_valid;

  function automatic logic [20:0] exp_pack(input logic [15:0] d, input logic c, input logic e);
    logic z;
    z = (d == 16'h0000);
    return {d, z, d[15] & ~z, ~d[15] & ~z, c, e};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: compare/pop at the negedge, record accepts, return at posedge+1
  task automatic cycle();
    logic [20:0] obs;
    @(negedge clk);
    cyc++;
    obs = {out_data, flag_z, flag_n, flag_p, flag_c, err};
    smp_in_ready  = in_ready;
    smp_out_valid = out_valid;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else if (out_ready) begin
        $display("txn %0d: out_data=%h z=%b n=%b p=%b c=%b err=%b", txn,
                 out_data, flag_z, flag_n, flag_p, flag_c, err);
        txn++;
        check("result", 32'(obs), 32'(sb_q.pop_front()));
      end else begin
        check("held_result", 32'(obs), 32'(sb_q[0]));
      end
    end
    acc_now = in_valid && in_ready;
    if (acc_now) sb_q.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] ed, input logic ec, input logic ee);
    op       = o;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    pend     = exp_pack(ed, ec, ee);
  endtask

  task automatic wait_accept();
    acc_now = 1'b0;
    for (int k = 0; k < 64 && !acc_now; k++) cycle();
    if (!acc_now) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] ed, input logic ec, input logic ee);
    drive(o, av, bv, ed, ec, ee);
    wait_accept();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) cycle();
    check("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int c0;
    int lat;
    int ir_low;
    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'h0;
    a         = 16'h0000;
    b         = 16'h0000;
    pend      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({out_valid, out_data, flag_z, flag_n, flag_p, flag_c, err}),
          32'({1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Single ADD, latency 1
    issue(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("add_latency1_valid", 32'(out_valid), 32'd1);
    drain();

    // Back-to-back directed ops, one per cycle
    c0 = cyc;
    issue(4'h1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0);
    issue(4'h1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0);
    issue(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    issue(4'h9, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
    issue(4'hA, 16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0);
    issue(4'hA, 16'h0002, 16'h0001, 16'h0000, 1'b0, 1'b0);
    issue(4'h8, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0);
    issue(4'hB, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
    issue(4'h2, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0);
    issue(4'h3, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 1'b0);
    issue(4'h6, 16'h8001, 16'h0004, 16'h1800, 1'b0, 1'b0);
    issue(4'h4, 16'h8001, 16'h0004, 16'h0018, 1'b0, 1'b0);
    issue(4'h5, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0);
    issue(4'h5, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0);
    issue(4'h7, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0);
    issue(4'hC, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b0);
    issue(4'hD, 16'h1111, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0);
    issue(4'hE, 16'h00AB, 16'h00CD, 16'hABCD, 1'b0, 1'b0);
    check("throughput_cycles", 32'(cyc - c0), 32'd18);
    drain();

    // Backpressure: stall two cycles, data held, then drain in order
    issue(4'h0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
    issue(4'h2, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(4'h1, 16'h0009, 16'h0004, 16'h0005, 1'b1, 1'b0);
    cycle();
    check("bp_in_ready_0", 32'(smp_in_ready), 32'd0);
    cycle();
    check("bp_in_ready_1", 32'(smp_in_ready), 32'd0);
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Op F: multiply or illegal, with latency and in_ready profile
`ifdef ALU_PIPE_MUL_EN
    issue(4'hF, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
`else
    issue(4'hF, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1);
`endif
    in_valid = 1'b0;
    lat      = 0;
    ir_low   = 0;
    smp_out_valid = 1'b0;
    while (!smp_out_valid && lat < 40) begin
      cycle();
      lat++;
      if (!smp_in_ready) ir_low++;
    end
`ifdef ALU_PIPE_MUL_EN
    check("mul_latency", 32'(lat), 32'd17);
    check("mul_in_ready_low", 32'(ir_low), 32'd16);
`else
    check("opf_latency", 32'(lat), 32'd1);
    check("opf_in_ready_low", 32'(ir_low), 32'd0);
`endif
    drain();

`ifdef ALU_PIPE_MUL_EN
    issue(4'hF, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0);
    issue(4'hF, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    issue(4'h0, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0);
    drain();
`endif

    // Async reset while a result is held under backpressure
    out_ready = 1'b0;
    issue(4'h2, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
    in_valid = 1'b0;
    cycle();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'({out_valid, out_data, flag_z, flag_n, flag_p, flag_c, err}),
          32'({1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    sb_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef ALU_PIPE_MUL_EN
    // Reset in the middle of a multiply discards it
    issue(4'hF, 16'h0007, 16'h0009, 16'h003F, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (4) cycle();
    #1 rst_n = 1'b0;
    #1;
    check("mid_mul_rst_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_mul_rst_ready", 32'(in_ready), 32'd1);
`endif

    issue(4'h0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0);
    drain();
    // Nothing further may emerge after the pipeline is empty
    repeat (20) cycle();
    check("idle_no_output", 32'(smp_out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
